// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end.
// IF_ADEL_EN adds an address-error flag to every buffered entry.
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
`ifdef IF_ADEL_EN
    logic        adel;
`endif
  } fetch_entry_t;

  typedef enum logic {IDLE, WAIT} fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Circular instruction buffer: push/pop, full flush, and a branch flush
// that keeps only the entry behind the head (the delay slot).
module if_inst_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_all_i,
  input  logic         keep_second_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o
);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [AW:0]     cnt_q;
  logic            wr_en;

  assign wr_en = push_i & ~flush_all_i & ~keep_second_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_all_i) begin
      wr_q  <= rd_q;
      cnt_q <= '0;
    end else if (keep_second_i) begin
      // Head is consumed, entry[1] survives, everything after it is discarded.
      rd_q  <= rd_q + AW'(1);
      wr_q  <= rd_q + AW'(2);
      cnt_q <= (AW+1)'(1);
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: one-outstanding memory requests, instruction buffer,
// delay-slot-aware redirects and exception flush. Optional IF_ADEL_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc4_o,
`ifdef IF_ADEL_EN
  output logic        id_adel_o,
`endif
  input  logic        id_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_i,
  input  logic [31:0] exc_pc_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic         drop_q, drop_d;
  fetch_entry_t hold_q;

  logic         push, pop, flush_all, keep_second;
  fetch_entry_t push_data, head;
  logic [CW-1:0] count;
  logic         space, misal, issue, consume;

`ifdef IF_ADEL_EN
  logic adel_stall_q, adel_stall_d;
  assign misal       = |fetch_pc_q[1:0];
  assign inst_addr_o = fetch_pc_q;
`else
  assign misal       = 1'b0;
  assign inst_addr_o = {fetch_pc_q[31:2], 2'b00};
`endif

  // Slot check: in IDLE nothing is in flight, so a free slot is count < depth.
  assign space      = count < CW'(FIFO_DEPTH);
  assign inst_req_o = ~rst_i & (state_q == IDLE) & space & ~misal;
  assign issue      = inst_req_o & inst_addr_ok_i;
  assign id_valid_o = count != '0;
  assign consume    = id_valid_o & ~id_stall_i;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    drop_d       = drop_q;
    push         = 1'b0;
    pop          = consume;
    flush_all    = 1'b0;
    keep_second  = 1'b0;
    push_data    = '0;
    push_data.instr = inst_rdata_i;
    push_data.pc4   = req_pc_q + 32'd4;
`ifdef IF_ADEL_EN
    adel_stall_d = adel_stall_q;
`endif

    if (issue) begin
      state_d      = WAIT;
      req_pc_d     = inst_addr_o;
      fetch_pc_d   = pend_valid_q ? pend_pc_q : fetch_pc_q + 32'd4;
      pend_valid_d = 1'b0;
    end
    if (state_q == WAIT && inst_data_ok_i) begin
      state_d = IDLE;
      if (drop_q) drop_d = 1'b0;
      else        push   = 1'b1;
    end
`ifdef IF_ADEL_EN
    // Misaligned fetch: synthesize a flagged entry and park until redirected.
    if (state_q == IDLE && misal && space && !adel_stall_q) begin
      push            = 1'b1;
      push_data.instr = '0;
      push_data.pc4   = fetch_pc_q + 32'd4;
      push_data.adel  = 1'b1;
      adel_stall_d    = 1'b1;
    end
`endif

    if (consume && redirect_i) begin
      if (count >= CW'(2)) begin
        keep_second  = 1'b1;
        pop          = 1'b0;
        push         = 1'b0;
        fetch_pc_d   = redirect_pc_i;
        pend_valid_d = 1'b0;
        drop_d       = (state_d == WAIT);
`ifdef IF_ADEL_EN
        adel_stall_d = 1'b0;
`endif
      end else if (state_q == WAIT || issue) begin
        // The word in flight (or issuing now) is the delay slot.
        fetch_pc_d   = redirect_pc_i;
        pend_valid_d = 1'b0;
`ifdef IF_ADEL_EN
        adel_stall_d = 1'b0;
`endif
      end else begin
        // Delay slot not yet requested: fetch it first, then jump.
        pend_pc_d    = redirect_pc_i;
        pend_valid_d = 1'b1;
      end
    end

    if (exc_i) begin
      flush_all    = 1'b1;
      keep_second  = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      fetch_pc_d   = exc_pc_i;
      pend_valid_d = 1'b0;
      drop_d       = (state_d == WAIT);
`ifdef IF_ADEL_EN
      adel_stall_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      hold_q       <= '0;
`ifdef IF_ADEL_EN
      adel_stall_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
      if (id_valid_o) hold_q <= head;
`ifdef IF_ADEL_EN
      adel_stall_q <= adel_stall_d;
`endif
    end
  end

  if_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .data_i        (push_data),
    .pop_i         (pop),
    .flush_all_i   (flush_all),
    .keep_second_i (keep_second),
    .head_o        (head),
    .count_o       (count)
  );

  // Outputs hold the last presented head while the buffer is empty.
  assign id_instr_o = id_valid_o ? head.instr : hold_q.instr;
  assign id_pc4_o   = id_valid_o ? head.pc4   : hold_q.pc4;
`ifdef IF_ADEL_EN
  assign id_adel_o  = id_valid_o ? head.adel  : hold_q.adel;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: memory model returns ~addr as the word.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc4_o;
`ifdef IF_ADEL_EN
  logic        id_adel_o;
`endif
  logic        id_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        exc_i;
  logic [31:0] exc_pc_i;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .id_valid_o     (id_valid_o),
    .id_instr_o     (id_instr_o),
    .id_pc4_o       (id_pc4_o),
`ifdef IF_ADEL_EN
    .id_adel_o      (id_adel_o),
`endif
    .id_stall_i     (id_stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .exc_i          (exc_i),
    .exc_pc_i       (exc_pc_i)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        adel;
  } exp_t;

  localparam logic [31:0] A  = 32'hBFC0_0000;
  localparam logic [31:0] E  = 32'hBFC0_0380;

  exp_t        exp_out[$];
  logic [31:0] exp_req[$];
  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int lat    = 1;
  bit mem_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t ent(input logic [31:0] a, input logic adel);
    exp_t e;
    e.instr = adel ? 32'h0 : ~a;
    e.pc4   = a + 32'd4;
    e.adel  = adel;
    return e;
  endfunction

  // Memory model: accepts when enabled, returns ~addr after lat cycles.
  bit          busy = 1'b0;
  int          cnt  = 0;
  logic [31:0] baddr;
  bit          acc  = 1'b0;
  logic [31:0] aaddr;
  always @(negedge clk) begin
    #1;
    inst_data_ok_i = 1'b0;
    if (acc) begin busy = 1'b1; cnt = lat; baddr = aaddr; end
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = ~baddr;
        busy           = 1'b0;
      end
    end
    inst_addr_ok_i = mem_en;
    #1;
    acc   = inst_req_o && inst_addr_ok_i;
    aaddr = inst_addr_o;
    if (acc) begin
      n_acc++;
      if (exp_req.size() > 0) chk("req_addr", aaddr, exp_req.pop_front());
    end
  end

  // Output monitor: every consumed head is compared against the queue.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_i && id_valid_o && !id_stall_i) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got pc4 %h expected none", id_pc4_o);
      end else begin
        e = exp_out.pop_front();
        chk("out_instr", id_instr_o, e.instr);
        chk("out_pc4", id_pc4_o, e.pc4);
`ifdef IF_ADEL_EN
        chk("out_adel", {31'b0, id_adel_o}, {31'b0, e.adel});
`endif
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; id_stall_i = 1'b1; redirect_i = 1'b0; exc_i = 1'b0;
    mem_en = 1'b0; lat = 1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", {31'b0, inst_req_o}, 32'd0);
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_instr", id_instr_o, 32'd0);
    chk("rst_pc4", id_pc4_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      redirect_i = 1'b0;
      exc_i      = 1'b0;
      id_stall_i = (exp_out.size() == 0);
      if (exp_out.size() == 0) break;
    end
    chk("drain_out_left", exp_out.size(), 32'd0);
    chk("drain_req_left", exp_req.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_i = 1'b1; id_stall_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    exc_i = 1'b0; exc_pc_i = '0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;

    // Sequential fill under stall; no request beyond the fourth.
    do_reset();
    for (int i = 0; i < 4; i++) exp_req.push_back(A + 32'(4 * i));
    mem_en = 1'b1;
    repeat (14) @(negedge clk);
    #3;
    chk("t1_valid", {31'b0, id_valid_o}, 32'd1);
    chk("t1_head_pc4", id_pc4_o, 32'hBFC0_0004);
    chk("t1_head_instr", id_instr_o, ~A);
    chk("t1_n_acc", n_acc, 32'd4);
    chk("t1_req_left", exp_req.size(), 32'd0);

    // Branch on a full buffer: delay slot kept, A+8/A+12 discarded.
    @(negedge clk);
    exp_out.push_back(ent(A, 1'b0));
    exp_out.push_back(ent(A + 32'd4, 1'b0));
    exp_out.push_back(ent(32'h8000_0100, 1'b0));
    exp_out.push_back(ent(32'h8000_0104, 1'b0));
    exp_req.push_back(32'h8000_0100);
    exp_req.push_back(32'h8000_0104);
    id_stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    drain(40);

    // Branch with only the head buffered and nothing in flight.
    do_reset();
    exp_req.push_back(A);
    exp_req.push_back(A + 32'd4);
    exp_req.push_back(32'h8000_0200);
    mem_en = 1'b1;
    @(negedge clk);
    mem_en = 1'b0;
    repeat (3) @(negedge clk);
    exp_out.push_back(ent(A, 1'b0));
    exp_out.push_back(ent(A + 32'd4, 1'b0));
    exp_out.push_back(ent(32'h8000_0200, 1'b0));
    id_stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    @(negedge clk);
    redirect_i = 1'b0; mem_en = 1'b1;
    drain(40);

    // Exception while a fetch is in flight: the returning word is dropped.
    do_reset();
    exp_req.push_back(A);
    exp_req.push_back(A + 32'd4);
    exp_req.push_back(E);
    mem_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid_o) break;
    end
    chk("t4_head_valid", {31'b0, id_valid_o}, 32'd1);
    lat = 3;
    @(negedge clk);
    mem_en = 1'b0; exc_i = 1'b1; exc_pc_i = E;
    @(negedge clk);
    exc_i = 1'b0; mem_en = 1'b1; lat = 1;
    #3;
    chk("t4_valid_after_exc", {31'b0, id_valid_o}, 32'd0);
    exp_out.push_back(ent(E, 1'b0));
    drain(40);

    // Exception and redirect together: exception wins, no delay slot.
    do_reset();
    for (int i = 0; i < 4; i++) exp_req.push_back(A + 32'(4 * i));
    exp_req.push_back(E);
    mem_en = 1'b1;
    repeat (14) @(negedge clk);
    exp_out.push_back(ent(A, 1'b0));
    exp_out.push_back(ent(E, 1'b0));
    id_stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    exc_i = 1'b1; exc_pc_i = E;
    drain(40);

`ifdef IF_ADEL_EN
    // Misaligned redirect target produces a flagged entry and no request.
    do_reset();
    for (int i = 0; i < 4; i++) exp_req.push_back(A + 32'(4 * i));
    mem_en = 1'b1;
    repeat (14) @(negedge clk);
    exp_out.push_back(ent(A, 1'b0));
    exp_out.push_back(ent(A + 32'd4, 1'b0));
    exp_out.push_back(ent(32'h8000_0102, 1'b1));
    id_stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    drain(40);
    snap = n_acc;
    repeat (6) @(negedge clk);
    #3;
    chk("t6_no_acc", n_acc, snap);
    chk("t6_no_req", {31'b0, inst_req_o}, 32'd0);
    chk("t6_hold_adel", {31'b0, id_adel_o}, 32'd1);
`else
    snap = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
